task_dispatcher: RTL and testbench

- Upstream stage of the task executor.
- Accepts tasks (8-bit ID plus priority) from producers into a small on-chip queue.
- Issues one task at a time to the executor via a start/task handshake, then waits for its done pulse.
- Selection rule: highest priority first; FIFO order among equal priorities. Completed or timed-out tasks are reported to the scheduler status logic.

---
 rtl/task_sched_pkg.sv | 28 ++
 rtl/task_prio_select.sv | 33 +++
 rtl/task_dispatcher.sv | 179 +++++++++++++++++
 tb/tb_task_dispatcher.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_sched_pkg.sv
// Shared types and default widths for the task scheduling blocks.
package task_sched_pkg;

    // Default task ID width, shared with the executor's task port.
    localparam int TASK_W = 8;

    // Default priority width; a larger value is more urgent.
    localparam int PRIO_W = 2;

    // Dispatcher control states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // One queued task as seen by producers.
    typedef struct packed {
        logic [TASK_W-1:0] id;
        logic [PRIO_W-1:0] prio;
    } task_entry_t;

    // True when priority a is strictly more urgent than priority b.
    function automatic logic prio_beats(input logic [PRIO_W-1:0] a,
                                        input logic [PRIO_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/task_prio_select.sv
// Combinational selector: picks the lowest-index valid entry that holds
// the highest priority present among all valid entries.
module task_prio_select
    import task_sched_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PRIO_W = task_sched_pkg::PRIO_W,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic [PRIO_W-1:0] prio [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    logic [PRIO_W-1:0] best_prio;

    // Scan from slot 0 upward; a strictly greater priority is needed to
    // displace the current winner, so ties keep the oldest slot.
    always_comb begin
        best_prio = '0;
        idx       = '0;
        found     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (!found || (prio[i] > best_prio))) begin
                found     = 1'b1;
                best_prio = prio[i];
                idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// Task dispatcher: queues producer tasks, issues the most urgent one to the
// executor, then waits for its done pulse or abandons it after a timeout.
module task_dispatcher
    import task_sched_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TASK_W  = task_sched_pkg::TASK_W,
    parameter int PRIO_W  = task_sched_pkg::PRIO_W,
    parameter int TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [TASK_W-1:0]          enq_task,
    input  logic [PRIO_W-1:0]          enq_prio,
    output logic                       exec_start,
    output logic [TASK_W-1:0]          exec_task,
    input  logic                       exec_done,
    output logic                       done_valid,
    output logic [TASK_W-1:0]          done_task,
    output logic                       timeout_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT);

    // Queue storage, slot 0 is the oldest entry.
    logic [TASK_W-1:0] q_id     [DEPTH];
    logic [PRIO_W-1:0] q_prio   [DEPTH];
    logic [TASK_W-1:0] q_id_n   [DEPTH];
    logic [PRIO_W-1:0] q_prio_n [DEPTH];
    logic [CNT_W-1:0]  count_n;
    logic [CNT_W-1:0]  wr_slot;
    logic [DEPTH-1:0]  valid_mask;

    // Selector results.
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;

    // Handshake qualifiers.
    logic              do_enq;
    logic              do_deq;

    // FSM state and registered outputs with their next values.
    state_t            state;
    state_t            state_n;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_n;
    logic              exec_start_n;
    logic [TASK_W-1:0] exec_task_n;
    logic              done_valid_n;
    logic [TASK_W-1:0] done_task_n;
    logic              timeout_err_n;

    // Slots below the occupancy count hold live tasks.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = (CNT_W'(i) < count);
        end
    end

    task_prio_select #(
        .DEPTH  (DEPTH),
        .PRIO_W (PRIO_W),
        .IDX_W  (IDX_W)
    ) u_select (
        .prio  (q_prio),
        .valid (valid_mask),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Ready depends only on occupancy, so a same-cycle dispatch never
    // frees a slot for an offer made while the queue is full.
    assign enq_ready = (count < CNT_W'(DEPTH));
    assign do_enq    = enq_valid && enq_ready;
    assign do_deq    = (state == IDLE) && sel_found;
    assign busy      = (state == WAIT);

    // Next queue image: close the gap left by a dispatched slot, then
    // append any accepted task just past the surviving entries.
    always_comb begin
        q_id_n   = q_id;
        q_prio_n = q_prio;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (do_deq && (IDX_W'(i) >= sel_idx)) begin
                q_id_n[i]   = q_id[i+1];
                q_prio_n[i] = q_prio[i+1];
            end
        end
        wr_slot = count - CNT_W'(do_deq);
        for (int i = 0; i < DEPTH; i++) begin
            if (do_enq && (CNT_W'(i) == wr_slot)) begin
                q_id_n[i]   = enq_task;
                q_prio_n[i] = enq_prio;
            end
        end
        count_n = count + CNT_W'(do_enq) - CNT_W'(do_deq);
    end

    // Slot contents need no reset because the count alone marks validity.
    always_ff @(posedge clk) begin
        q_id   <= q_id_n;
        q_prio <= q_prio_n;
    end

    // Occupancy counter, emptied by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_n;
        end
    end

    // Dispatch control: issue in IDLE, then wait for done or timeout.
    always_comb begin
        state_n       = state;
        timer_n       = timer;
        exec_start_n  = 1'b0;
        exec_task_n   = exec_task;
        done_valid_n  = 1'b0;
        done_task_n   = done_task;
        timeout_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    exec_task_n  = q_id[sel_idx];
                    exec_start_n = 1'b1;
                    timer_n      = '0;
                    state_n      = WAIT;
                end
            end
            WAIT: begin
                if (exec_done && !exec_start) begin
                    done_valid_n = 1'b1;
                    done_task_n  = exec_task;
                    state_n      = IDLE;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    timeout_err_n = 1'b1;
                    done_task_n   = exec_task;
                    state_n       = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, timer and registered outputs; reset drops any in-flight task.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            exec_start  <= 1'b0;
            exec_task   <= '0;
            done_valid  <= 1'b0;
            done_task   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            exec_start  <= exec_start_n;
            exec_task   <= exec_task_n;
            done_valid  <= done_valid_n;
            done_task   <= done_task_n;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: tb/tb_task_dispatcher.sv
// Scoreboard bench for task_dispatcher with a 7-cycle executor model.
module tb_task_dispatcher;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;
    localparam int EXEC_LAT = 7;

    logic       clk;
    logic       rst;
    logic       enq_valid;
    logic       enq_ready;
    logic [7:0] enq_task;
    logic [1:0] enq_prio;
    logic       exec_start;
    logic [7:0] exec_task;
    logic       exec_done;
    logic       done_valid;
    logic [7:0] done_task;
    logic       timeout_err;
    logic       busy;
    logic [3:0] count;

    typedef struct {
        logic [7:0] id;
        logic       isTimeout;
        int         latency;
    } done_exp_t;

    logic [7:0] expIssue [$];
    done_exp_t  expDone  [$];

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int lastStartCyc = 0;
    int doneAt      = 0;
    bit execAuto    = 1'b1;
    bit execArmed   = 1'b0;
    bit manualDone  = 1'b0;

    task_dispatcher #(
        .DEPTH   (DEPTH),
        .TASK_W  (8),
        .PRIO_W  (2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_task    (enq_task),
        .enq_prio    (enq_prio),
        .exec_start  (exec_start),
        .exec_task   (exec_task),
        .exec_done   (exec_done),
        .done_valid  (done_valid),
        .done_task   (done_task),
        .timeout_err (timeout_err),
        .busy        (busy),
        .count       (count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure start-to-completion distance.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one value and report a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Record a failure that has no value pair, such as an unexpected pulse.
    task automatic reportFail(input string name, input logic [31:0] actual);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: got 0x%0h, expected no event", name, actual);
    endtask

    // Queue the issue and completion expectations for one task.
    task automatic expectTask(input logic [7:0] id, input logic isTimeout,
                              input int latency);
        done_exp_t e;
        e.id        = id;
        e.isTimeout = isTimeout;
        e.latency   = latency;
        expIssue.push_back(id);
        expDone.push_back(e);
    endtask

    // Offer one task for exactly one clock edge; returns 1 time unit after it.
    task automatic applyStimulus(input logic [7:0] id, input logic [1:0] prio);
        enq_valid = 1'b1;
        enq_task  = id;
        enq_prio  = prio;
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
    endtask

    // Wait for an empty, idle dispatcher within a bounded number of cycles.
    task automatic waitIdle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(count == 0 && !busy && !exec_start) && n < 1000);
        checkOutput(name, 32'(n < 1000), 32'd1);
    endtask

    // Executor model: done is presented so the DUT samples it EXEC_LAT edges
    // after the start edge; manualDone lets a test pulse done itself.
    always @(negedge clk) begin
        exec_done = manualDone;
        if (rst) begin
            execArmed = 1'b0;
        end else begin
            if (execArmed && cyc == doneAt) begin
                exec_done = 1'b1;
                execArmed = 1'b0;
            end
            if (exec_start && execAuto) begin
                execArmed = 1'b1;
                doneAt    = cyc + EXEC_LAT - 1;
            end
        end
    end

    done_exp_t mon;
    logic [7:0] monIssue;

    // Monitor: pop expectations whenever the DUT presents an issue or result.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("done_valid/timeout_err exclusive", 32'(done_valid & timeout_err), 32'd0);
            if (exec_start) begin
                if (expIssue.size() == 0) begin
                    reportFail("unexpected issue", 32'(exec_task));
                end else begin
                    monIssue = expIssue.pop_front();
                    checkOutput("issue order", 32'(exec_task), 32'(monIssue));
                end
                lastStartCyc = cyc;
            end
            if (done_valid || timeout_err) begin
                if (expDone.size() == 0) begin
                    reportFail("unexpected completion", 32'(done_task));
                end else begin
                    mon = expDone.pop_front();
                    checkOutput("done_task", 32'(done_task), 32'(mon.id));
                    checkOutput("timeout_err kind", 32'(timeout_err), 32'(mon.isTimeout));
                    if (mon.latency > 0) begin
                        checkOutput("completion latency", 32'(cyc - lastStartCyc), 32'(mon.latency));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst       = 1'b1;
        enq_valid = 1'b0;
        enq_task  = '0;
        enq_prio  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        checkOutput("reset exec_start", 32'(exec_start), 32'd0);
        checkOutput("reset exec_task", 32'(exec_task), 32'd0);
        checkOutput("reset done_valid", 32'(done_valid), 32'd0);
        checkOutput("reset done_task", 32'(done_task), 32'd0);
        checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset enq_ready", 32'(enq_ready), 32'd1);

        // Basic dispatch.
        $display("[TB] basic dispatch");
        expectTask(8'h3A, 1'b0, EXEC_LAT);
        applyStimulus(8'h3A, 2'd1);
        checkOutput("basic count after enqueue", 32'(count), 32'd1);
        checkOutput("basic no bypass", 32'(exec_start), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("basic exec_start", 32'(exec_start), 32'd1);
        checkOutput("basic exec_task", 32'(exec_task), 32'h3A);
        checkOutput("basic busy", 32'(busy), 32'd1);
        checkOutput("basic count after issue", 32'(count), 32'd0);
        waitIdle("basic drain");

        // Priority plus FIFO ordering.
        $display("[TB] priority ordering");
        expectTask(8'h01, 1'b0, EXEC_LAT);
        expectTask(8'h20, 1'b0, EXEC_LAT);
        expectTask(8'h40, 1'b0, EXEC_LAT);
        expectTask(8'h10, 1'b0, EXEC_LAT);
        expectTask(8'h30, 1'b0, EXEC_LAT);
        applyStimulus(8'h01, 2'd0);
        applyStimulus(8'h10, 2'd1);
        applyStimulus(8'h20, 2'd3);
        applyStimulus(8'h30, 2'd1);
        applyStimulus(8'h40, 2'd3);
        waitIdle("priority drain");

        // Full queue.
        $display("[TB] full queue");
        execAuto = 1'b0;
        expectTask(8'h02, 1'b0, 0);
        for (int i = 0; i < 8; i++) expectTask(8'h81 + 8'(i), 1'b0, EXEC_LAT);
        expectTask(8'h99, 1'b0, EXEC_LAT);
        applyStimulus(8'h02, 2'd0);
        for (int i = 0; i < 8; i++) applyStimulus(8'h81 + 8'(i), 2'd2);
        checkOutput("full count", 32'(count), 32'd8);
        checkOutput("full enq_ready", 32'(enq_ready), 32'd0);
        enq_valid = 1'b1;
        enq_task  = 8'h99;
        enq_prio  = 2'd0;
        @(posedge clk);
        #1;
        checkOutput("full offer refused", 32'(count), 32'd8);
        manualDone = 1'b1;
        @(posedge clk);
        #1;
        manualDone = 1'b0;
        checkOutput("full count at done", 32'(count), 32'd8);
        execAuto = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("full count during dispatch", 32'(count), 32'd7);
        checkOutput("full enq_ready after dispatch", 32'(enq_ready), 32'd1);
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        checkOutput("full 9th accepted", 32'(count), 32'd8);
        waitIdle("full drain");

        // Simultaneous enqueue and dispatch.
        $display("[TB] simultaneous enqueue and dispatch");
        execAuto = 1'b0;
        expectTask(8'h03, 1'b0, 0);
        expectTask(8'hA2, 1'b0, EXEC_LAT);
        expectTask(8'hA1, 1'b0, EXEC_LAT);
        expectTask(8'hA3, 1'b0, EXEC_LAT);
        expectTask(8'h55, 1'b0, EXEC_LAT);
        applyStimulus(8'h03, 2'd0);
        applyStimulus(8'hA1, 2'd1);
        applyStimulus(8'hA2, 2'd2);
        applyStimulus(8'hA3, 2'd1);
        checkOutput("simul count before", 32'(count), 32'd3);
        manualDone = 1'b1;
        @(posedge clk);
        #1;
        manualDone = 1'b0;
        checkOutput("simul idle", 32'(busy), 32'd0);
        execAuto = 1'b1;
        applyStimulus(8'h55, 2'd1);
        checkOutput("simul count unchanged", 32'(count), 32'd3);
        checkOutput("simul issued", 32'(exec_task), 32'hA2);
        waitIdle("simul drain");

        // Timeout, then a late done that must be ignored.
        $display("[TB] timeout");
        execAuto = 1'b0;
        expectTask(8'h77, 1'b1, TIMEOUT);
        applyStimulus(8'h77, 2'd1);
        @(posedge clk);
        #1;
        checkOutput("timeout busy", 32'(busy), 32'd1);
        waitIdle("timeout drain");
        manualDone = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        manualDone = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("late done busy", 32'(busy), 32'd0);
        checkOutput("late done count", 32'(count), 32'd0);
        checkOutput("late done exec_start", 32'(exec_start), 32'd0);

        // Reset during WAIT with four queued tasks.
        $display("[TB] reset mid-operation");
        expIssue.push_back(8'h04);
        applyStimulus(8'h04, 2'd0);
        applyStimulus(8'hB1, 2'd1);
        applyStimulus(8'hB2, 2'd2);
        applyStimulus(8'hB3, 2'd3);
        applyStimulus(8'hB4, 2'd0);
        checkOutput("pre-reset count", 32'(count), 32'd4);
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid reset exec_start", 32'(exec_start), 32'd0);
        checkOutput("mid reset exec_task", 32'(exec_task), 32'd0);
        checkOutput("mid reset done_valid", 32'(done_valid), 32'd0);
        checkOutput("mid reset done_task", 32'(done_task), 32'd0);
        checkOutput("mid reset timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset count", 32'(count), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("post reset busy", 32'(busy), 32'd0);
        checkOutput("post reset count", 32'(count), 32'd0);
        execAuto = 1'b1;

        checkOutput("issue scoreboard empty", 32'(expIssue.size()), 32'd0);
        checkOutput("done scoreboard empty", 32'(expDone.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
